roclk_feed_ctrl: RTL and testbench

ROCLK_FEED_CTRL -- requirements
Module: roclk_feed_ctrl

---
 rtl/roclk_feed_ctrl.sv | 121 ++++++++++++
 tb/tb_roclk_feed_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/roclk_feed_ctrl.sv
`default_nettype none
// ============================================================================
// roclk_feed_ctrl : feeds a serial feature stream into a sequential BNN core,
// restarts it, waits a fixed run time and hands the prediction downstream.
// Revision: 1.0
// ============================================================================
module roclk_feed_ctrl #(
  parameter int FEAT_CNT   = 4,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 4,
  parameter int RUN_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] core_features,
  output logic                          core_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]  core_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  out_class
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] feat_idx, feat_idx_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic             accept;
  logic             capture;

  always_comb begin
    state_nxt    = state;
    feat_idx_nxt = feat_idx;
    run_cnt_nxt  = run_cnt;
    capture      = 1'b0;
    accept       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state)
      LOAD: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (in_valid) begin
          if (feat_idx == LAST_IDX) begin
            feat_idx_nxt = '0;
            state_nxt    = KICK;
          end else begin
            feat_idx_nxt = feat_idx + 1'b1;
          end
        end
      end
      KICK: begin
        run_cnt_nxt = '0;
        state_nxt   = RUN;
      end
      RUN: begin
        // The final RUN cycle is the one whose closing edge latches the result.
        if (run_cnt == LAST_RUN) begin
          run_cnt_nxt = '0;
          capture     = 1'b1;
          state_nxt   = DONE;
        end else begin
          run_cnt_nxt = run_cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      feat_idx  <= '0;
      run_cnt   <= '0;
      out_class <= '0;
    end else begin
      state    <= state_nxt;
      feat_idx <= feat_idx_nxt;
      run_cnt  <= run_cnt_nxt;
      if (capture) begin
        out_class <= core_prediction;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < FEAT_CNT; k++) begin : g_slice
      always_ff @(posedge clk) begin
        if (rst) begin
          core_features[k*FEAT_BITS +: FEAT_BITS] <= '0;
        end else if (accept && (feat_idx == IDX_W'(k))) begin
          core_features[k*FEAT_BITS +: FEAT_BITS] <= in_data;
        end
      end
    end
  endgenerate

  assign core_rst = rst || (state == KICK);

endmodule
`default_nettype wire

// File: tb/tb_roclk_feed_ctrl.sv
`default_nettype none
// ============================================================================
// tb_roclk_feed_ctrl : directed bench for roclk_feed_ctrl (default and
// RUN_CYCLES=1 / FEAT_CNT=2 instances).
// Revision: 1.0
// ============================================================================
module tb_roclk_feed_ctrl;
  localparam int RUN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'h0;
  logic [15:0] core_features;
  logic        core_rst;
  logic [1:0]  core_prediction = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_class;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [3:0]  b_in_data = 4'h0;
  logic [7:0]  b_features;
  logic        b_core_rst;
  logic [0:0]  b_pred = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [0:0]  b_out_class;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  roclk_feed_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_features(core_features), .core_rst(core_rst), .core_prediction(core_prediction),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class)
  );

  roclk_feed_ctrl #(.FEAT_CNT(2), .FEAT_BITS(4), .CLASS_CNT(2), .RUN_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .core_features(b_features), .core_rst(b_core_rst), .core_prediction(b_pred),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: four back-to-back words, ends one step after the last accept edge.
  task automatic send_words(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i*4 +: 4];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0h expected 0", in_ready); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %0h expected 1", core_rst); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    n_checks++; if (core_features !== 16'h0000) begin n_fail++; $display("FAIL reset_features: got %0h expected 0", core_features); end
    n_checks++; if (out_class !== 2'd0) begin n_fail++; $display("FAIL reset_out_class: got %0h expected 0", out_class); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %0h expected 1", in_ready); end
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release_core_rst: got %0h expected 0", core_rst); end
  endtask

  task automatic test_basic();
    core_prediction = 2'd1;
    send_words(16'h4321);
    n_checks++; if (core_features !== 16'h4321) begin n_fail++; $display("FAIL basic_features: got %0h expected 4321", core_features); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL basic_kick: got %0h expected 1", core_rst); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_kick_in_ready: got %0h expected 0", in_ready); end
    for (int i = 1; i <= RUN; i++) begin
      tick();
      if (i == 1) begin
        n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL basic_kick_one_cycle: got %0h expected 0", core_rst); end
      end
      if (i == RUN) core_prediction = 2'd2;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_run_no_valid cycle %0d: got %0h expected 0", i, out_valid); end
    end
    tick();
    core_prediction = 2'd3;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %0h expected 1", out_valid); end
    n_checks++; if (out_class !== 2'd2) begin n_fail++; $display("FAIL basic_out_class: got %0h expected 2", out_class); end
    tick();
    n_checks++; if (out_class !== 2'd2) begin n_fail++; $display("FAIL basic_class_stable: got %0h expected 2", out_class); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0h expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_to_load: got %0h expected 1", in_ready); end
  endtask

  task automatic test_gaps();
    logic [15:0] v;
    int n, kicks;
    v = 16'hDCBA;
    for (int i = 0; i < 8; i++) begin
      in_valid = ~i[0];
      in_data  = i[0] ? 4'hF : v[(i/2)*4 +: 4];
      if (i == 7) begin
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL gaps_kick: got %0h expected 1", core_rst); end
      end else begin
        n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL gaps_early_kick step %0d: got %0h expected 0", i, core_rst); end
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (core_features !== 16'hDCBA) begin n_fail++; $display("FAIL gaps_features: got %0h expected dcba", core_features); end
    n = 0; kicks = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (core_rst) kicks++;
      tick();
      n++;
    end
    n_checks++; if (n !== RUN) begin n_fail++; $display("FAIL gaps_latency: got %0d expected %0d", n, RUN); end
    n_checks++; if (kicks !== 0) begin n_fail++; $display("FAIL gaps_single_kick: got %0d extra expected 0", kicks); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    core_prediction = 2'd3;
    send_words(16'h8765);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done: got %0h expected 1", out_valid); end
    in_valid = 1'b1;
    in_data  = 4'h1;
    for (int i = 0; i < 5; i++) begin
      core_prediction = 2'(i);
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held %0d: got %0h expected 1", i, out_valid); end
      n_checks++; if (out_class !== 2'd3) begin n_fail++; $display("FAIL bp_class_held %0d: got %0h expected 3", i, out_class); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready %0d: got %0h expected 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %0h expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_load: got %0h expected 1", in_ready); end
    n_checks++; if (core_features !== 16'h8765) begin n_fail++; $display("FAIL bp_features: got %0h expected 8765", core_features); end
  endtask

  task automatic test_rst_load();
    int n;
    in_valid = 1'b1; in_data = 4'h3; tick();
    in_data = 4'h9; tick();
    in_valid = 1'b0;
    n_checks++; if (core_features !== 16'h8793) begin n_fail++; $display("FAIL rstl_partial: got %0h expected 8793", core_features); end
    rst = 1'b1;
    tick();
    n_checks++; if (core_features !== 16'h0000) begin n_fail++; $display("FAIL rstl_cleared: got %0h expected 0", core_features); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rstl_core_rst: got %0h expected 1", core_rst); end
    rst = 1'b0;
    in_valid = 1'b1; in_data = 4'h6; tick();
    in_data = 4'h7; tick();
    in_valid = 1'b0;
    n_checks++; if (core_features !== 16'h0076) begin n_fail++; $display("FAIL rstl_index0: got %0h expected 0076", core_features); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstl_still_load: got %0h expected 1", in_ready); end
    in_valid = 1'b1; in_data = 4'h8; tick();
    in_data = 4'h9; tick();
    in_valid = 1'b0;
    n_checks++; if (core_features !== 16'h9876) begin n_fail++; $display("FAIL rstl_fresh: got %0h expected 9876", core_features); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rstl_kick: got %0h expected 1", core_rst); end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_rst_run();
    int seen;
    send_words(16'h1111);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rstr_core_rst: got %0h expected 1", core_rst); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstr_no_valid: got %0h expected 0", out_valid); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstr_load: got %0h expected 1", in_ready); end
    n_checks++; if (out_class !== 2'd0) begin n_fail++; $display("FAIL rstr_class_cleared: got %0h expected 0", out_class); end
    seen = 0;
    for (int i = 0; i < RUN + 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstr_no_result: got %0d expected 0", seen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstr_idle_load: got %0h expected 1", in_ready); end
  endtask

  task automatic test_hold_valid();
    int n;
    logic [15:0] v;
    v = 16'hA50E;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = v[i*4 +: 4];
      tick();
    end
    in_data = 4'hF;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready %0d: got %0h expected 0", n, in_ready); end
      n_checks++; if (core_features !== 16'hA50E) begin n_fail++; $display("FAIL hold_features %0d: got %0h expected a50e", n, core_features); end
      tick();
      n++;
    end
    n_checks++; if (n !== RUN + 1) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", n, RUN + 1); end
    n_checks++; if (core_features !== 16'hA50E) begin n_fail++; $display("FAIL hold_features_done: got %0h expected a50e", core_features); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_run_one();
    b_pred = 1'b0;
    b_in_valid = 1'b1; b_in_data = 4'h3; tick();
    b_in_data = 4'h5; tick();
    b_in_valid = 1'b0;
    n_checks++; if (b_core_rst !== 1'b1) begin n_fail++; $display("FAIL r1_kick: got %0h expected 1", b_core_rst); end
    n_checks++; if (b_features !== 8'h53) begin n_fail++; $display("FAIL r1_features: got %0h expected 53", b_features); end
    tick();
    b_pred = 1'b1;
    n_checks++; if (b_core_rst !== 1'b0) begin n_fail++; $display("FAIL r1_run_core_rst: got %0h expected 0", b_core_rst); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL r1_run_no_valid: got %0h expected 0", b_out_valid); end
    tick();
    b_pred = 1'b0;
    n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL r1_valid: got %0h expected 1", b_out_valid); end
    n_checks++; if (b_out_class !== 1'b1) begin n_fail++; $display("FAIL r1_class: got %0h expected 1", b_out_class); end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL r1_back_to_load: got %0h expected 1", b_in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_rst_load();
    test_rst_run();
    test_hold_valid();
    test_run_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
